// File: rtl/alu_result_collector.sv
// Result FIFO behind the signed ALU: buffers {result, op} pairs and keeps a
// saturating running sum of the arithmetic results as they are drained.
module alu_result_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [2*WIDTH-1:0]      in_data,
    input  logic [1:0]                     in_op,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [2*WIDTH-1:0]      out_data,
    output logic [1:0]                     out_op,
    input  logic                           acc_clr,
    output logic signed [ACC_W-1:0]        acc,
    output logic                           acc_sat,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int RW = 2*WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    acc_sat_q, acc_sat_d;
    logic signed [RW-1:0]    data_mem [DEPTH];
    logic [1:0]              op_mem [DEPTH];
    logic                    push, pop;
    logic [ACC_W:0]          add_res;

    // Returns {overflow, saturated sum}; the sum is formed one bit wider so
    // overflow shows up as disagreement between the top two bits.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [RW-1:0]    b);
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W+1-RW){b[RW-1]}}, b};
        if (sum[ACC_W] == sum[ACC_W-1])
            return {1'b0, sum[ACC_W-1:0]};
        else if (sum[ACC_W])
            return {1'b1, ACC_MIN};
        else
            return {1'b1, ACC_MAX};
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = data_mem[rd_ptr_q];
    assign out_op    = op_mem[rd_ptr_q];
    assign count     = count_q;
    assign acc       = acc_q;
    assign acc_sat   = acc_sat_q;
    assign add_res   = sat_add(acc_q, out_data);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        acc_d     = acc_q;
        acc_sat_d = acc_sat_q;
        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        // Clear wins over the contribution of a simultaneous pop.
        if (acc_clr) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end else if (pop && !out_op[1]) begin
            acc_d = add_res[ACC_W-1:0];
            if (add_res[ACC_W])
                acc_sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    // Storage is not reset; entries are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data;
            op_mem[wr_ptr_q]   <= in_op;
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed scenarios plus random traffic,
// all checked against a queue-based model with clamped integer accumulation.
module tb_alu_result_collector;

    localparam int     DEPTH   = 4;
    localparam longint ACC_MAX = 524287;
    localparam longint ACC_MIN = -524288;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready;
    logic signed [15:0] in_data;
    logic [1:0]         in_op;
    logic               out_valid, out_ready;
    logic signed [15:0] out_data;
    logic [1:0]         out_op;
    logic               acc_clr;
    logic signed [19:0] acc;
    logic               acc_sat;
    logic [2:0]         count;
    logic               full, empty;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] mq_data[$];
    logic [1:0]         mq_op[$];
    longint             macc;
    bit                 msat;

    alu_result_collector #(.WIDTH(8), .DEPTH(DEPTH), .ACC_W(20)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
        .acc_clr(acc_clr), .acc(acc), .acc_sat(acc_sat),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit                 push, pop;
        logic signed [15:0] hd;
        logic [1:0]         ho;
        longint             sum;
        push = in_valid && (mq_data.size() < DEPTH);
        pop  = out_ready && (mq_data.size() > 0);
        hd = '0;
        ho = '0;
        @(posedge clk);
        if (pop) begin
            hd = mq_data.pop_front();
            ho = mq_op.pop_front();
        end
        if (acc_clr) begin
            macc = 0;
            msat = 0;
        end else if (pop && ho < 2) begin
            sum = macc + longint'(hd);
            if (sum > ACC_MAX) begin
                macc = ACC_MAX;
                msat = 1;
            end else if (sum < ACC_MIN) begin
                macc = ACC_MIN;
                msat = 1;
            end else begin
                macc = sum;
            end
        end
        if (push) begin
            mq_data.push_back(in_data);
            mq_op.push_back(in_op);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 0; in_data = '0; in_op = '0; out_ready = 0; acc_clr = 0;
        macc = 0; msat = 0;
        #12;
        checks++;
        if ({out_valid, empty, full, in_ready, acc_sat} !== 5'b01010) begin
            errors++;
            $display("FAIL reset_flags got ov/em/fu/ir/sat=%b expected 01010",
                     {out_valid, empty, full, in_ready, acc_sat});
        end
        checks++;
        if (count !== 3'd0 || acc !== 20'sd0) begin
            errors++;
            $display("FAIL reset_count_acc got count=%0d acc=%0d expected 0 0", count, acc);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        in_valid = 1; in_data = 16'h3F01; in_op = 2'd0; out_ready = 0;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sh3F01 || count !== 3'd1 || acc !== 20'sd0) begin
            errors++;
            $display("FAIL basic_push got ov=%b data=%h count=%0d acc=%0d expected 1 3f01 1 0",
                     out_valid, out_data, count, acc);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (acc !== 20'sd16129 || empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_pop got acc=%0d empty=%b expected 16129 1", acc, empty);
        end
    endtask

    task automatic test_full();
        logic signed [15:0] vals [4];
        vals[0] = -16'sd5; vals[1] = -16'sd6; vals[2] = -16'sd7; vals[3] = -16'sd8;
        acc_clr = 1;
        tick();
        acc_clr = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = vals[i]; in_op = 2'd1;
            tick();
        end
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_flags got full=%b in_ready=%b count=%0d expected 1 0 4",
                     full, in_ready, count);
        end
        in_data = 16'sd99;
        tick();
        in_valid = 0;
        checks++;
        if (count !== 3'd4 || out_data !== vals[0]) begin
            errors++;
            $display("FAIL full_refuse got count=%0d head=%0d expected 4 -5", count, out_data);
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i]) begin
                errors++;
                $display("FAIL full_drain[%0d] got valid=%b data=%0d expected 1 %0d",
                         i, out_valid, out_data, vals[i]);
            end
            tick();
        end
        out_ready = 0;
        checks++;
        if (acc !== -20'sd26 || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_acc got acc=%0d empty=%b expected -26 1", acc, empty);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [19:0] acc_before;
        acc_before = acc;
        in_valid = 1; out_ready = 1; in_op = 2'd2;
        for (int i = 0; i < 10; i++) begin
            in_data = (i == 0) ? 16'sh00FF : 16'($urandom);
            tick();
            checks++;
            if (count !== 3'd1 || out_data !== mq_data[0] || acc !== acc_before) begin
                errors++;
                $display("FAIL b2b[%0d] got count=%0d data=%h acc=%0d expected 1 %h %0d",
                         i, count, out_data, acc, mq_data[0], acc_before);
            end
        end
        in_valid = 0;
        tick();
        out_ready = 0;
    endtask

    task automatic test_saturation();
        acc_clr = 1;
        tick();
        acc_clr = 0;
        in_valid = 1; in_data = 16'sd16129; in_op = 2'd0; out_ready = 1;
        for (int i = 0; i < 33; i++) tick();
        in_valid = 0;
        checks++;
        if (acc !== 20'sd516128 || acc_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_32 got acc=%0d sat=%b expected 516128 0", acc, acc_sat);
        end
        tick();
        checks++;
        if (acc !== 20'sd524287 || acc_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_33 got acc=%0d sat=%b expected 524287 1", acc, acc_sat);
        end
        in_valid = 1; in_data = -16'sd1; in_op = 2'd1;
        tick();
        in_valid = 0;
        tick();
        out_ready = 0;
        checks++;
        if (acc !== 20'sd524286 || acc_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_back got acc=%0d sat=%b expected 524286 1", acc, acc_sat);
        end
    endtask

    task automatic test_clear();
        in_valid = 1; in_data = 16'sd100; in_op = 2'd0;
        tick();
        in_valid = 0; acc_clr = 1; out_ready = 1;
        tick();
        acc_clr = 0; out_ready = 0;
        checks++;
        if (acc !== 20'sd0 || acc_sat !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL clear_pop got acc=%0d sat=%b count=%0d expected 0 0 0", acc, acc_sat, count);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1; in_data = 16'sd500; in_op = 2'd0; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
        out_ready = 0;
        checks++;
        if (acc !== 20'sd500) begin
            errors++;
            $display("FAIL areset_setup got acc=%0d expected 500", acc);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = 16'(i + 7); in_op = 2'd1;
            tick();
        end
        in_valid = 0;
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 20'sd0) begin
            errors++;
            $display("FAIL areset_now got count=%0d valid=%b acc=%0d expected 0 0 0",
                     count, out_valid, acc);
        end
        mq_data.delete(); mq_op.delete(); macc = 0; msat = 0;
        #2;
        rst = 1'b1;
        in_valid = 1; in_data = 16'sh1234; in_op = 2'd3;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sh1234 || out_op !== 2'd3 || count !== 3'd1) begin
            errors++;
            $display("FAIL areset_push got valid=%b data=%h op=%0d count=%0d expected 1 1234 3 1",
                     out_valid, out_data, out_op, count);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_random();
        int unsigned n;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            acc_clr   = ($urandom_range(0, 40) == 0);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = 16'($urandom);
            tick();
            n = mq_data.size();
            checks++;
            if (count !== 3'(n) || empty !== (n == 0) || full !== (n == DEPTH) ||
                in_ready !== (n != DEPTH) || out_valid !== (n != 0)) begin
                errors++;
                $display("FAIL rand_state[%0d] got count=%0d em=%b fu=%b ir=%b ov=%b expected count=%0d",
                         i, count, empty, full, in_ready, out_valid, n);
            end
            checks++;
            if (longint'(acc) !== macc || acc_sat !== msat) begin
                errors++;
                $display("FAIL rand_acc[%0d] got acc=%0d sat=%b expected %0d %b",
                         i, acc, acc_sat, macc, msat);
            end
            if (n != 0) begin
                checks++;
                if (out_data !== mq_data[0] || out_op !== mq_op[0]) begin
                    errors++;
                    $display("FAIL rand_head[%0d] got %h/%0d expected %h/%0d",
                             i, out_data, out_op, mq_data[0], mq_op[0]);
                end
            end
        end
        in_valid = 0; out_ready = 0; acc_clr = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the registered 8-bit signed ALU. It takes each 16-bit signed ALU result and its 2-bit op tag, and buffers them in a small FIFO.
- The consumer drains the FIFO through a valid/ready handshake.
- Each drained arithmetic result (op 0 multiply, op 1 subtract) is added to a saturating signed accumulator. Logic/shift results (op 2, 3) pass through without being accumulated.

Parameters:
- WIDTH, 8: ALU operand width. Result width is 2*WIDTH.
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2.
- ACC_W, 2*WIDTH+4: accumulator width, signed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a result
- in_ready  out  1  collector can accept
- in_data  in  2*WIDTH  signed ALU result
- in_op  in  2  ctrl tag of that result
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_data  out  2*WIDTH  head result
- out_op  out  2  head op tag
- acc_clr  in  1  synchronous accumulator clear
- acc  out  ACC_W  signed running sum
- acc_sat  out  1  sticky saturation flag
- count  out  $clog2(DEPTH+1)  occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset (rst==0, async): read/write pointers=0, count=0, acc=0, acc_sat=0. Consequently out_valid=0, empty=1, full=0, in_ready=1. FIFO storage contents are don't-care.
- Reset mid-operation discards all buffered entries; no output is produced until new pushes arrive.
- push = in_valid && in_ready; in_ready = !full. There is no bypass: a full FIFO refuses input even if a pop occurs in the same cycle.
- pop = out_valid && out_ready; out_valid = !empty.
- out_data/out_op = storage[rd_ptr]. They are stable while out_valid=1 and no pop occurs.
- Latency: an entry pushed at edge N is visible on out_valid/out_data after edge N (1 cycle). Ordering is strict FIFO.
- Pointers increment modulo DEPTH on push/pop respectively.
- Count update per cycle:
  - push only: count+1
  - pop only: count−1
  - push and pop (only possible when non-empty, non-full): count unchanged, both pointers advance
- Producer must hold in_data/in_op while in_valid=1 && in_ready=0. Data offered while in_ready=0 is not captured.
- Accumulation, at the edge where pop=1 and out_op∈{0,1}:
  - sum = acc + sign-extend(out_data to ACC_W), computed at ACC_W+1 bits.
  - If sum > 2^(ACC_W−1)−1: acc=max positive, acc_sat=1.
  - If sum < −2^(ACC_W−1): acc=min negative, acc_sat=1.
  - Otherwise acc=sum.
  - When already saturated, further same-sign adds keep acc at the limit. Opposite-sign adds move acc off the limit normally; acc_sat stays 1.
- Pops with out_op∈{2,3} leave acc unchanged.
- acc_clr=1 at an edge: acc=0, acc_sat=0. This has priority over a simultaneous pop's contribution; the pop itself still completes.
- acc_clr does not affect FIFO state.

Test Plan:
- Reset release, then push in_data=16'h3F01 (127*127=16129), op=0, with out_ready=0 → next cycle out_valid=1, out_data=16'h3F01, count=1, acc=0. Raise out_ready → after pop, acc=16129, empty=1.
- Push 4 results (op=1, values −5,−6,−7,−8) with out_ready=0 → full=1, in_ready=0. A 5th offer (value 99) is not captured. Draining yields −5,−6,−7,−8 in order; acc=−26.
- Push/pop every cycle for 10 cycles with op=2, data 16'h00FF → count stays at 1 after the first cycle, ordering is preserved, and acc is unchanged.
- Pop 33 results of 16129 (op 0), ACC_W=20 → after 32 pops acc=516128 and acc_sat=0. After the 33rd, acc=524287 and acc_sat=1. Then one pop of −1 (op 1) → acc=524286, acc_sat=1.
- acc_clr asserted in the same cycle as a pop of 100 (op 0) → acc=0, acc_sat=0, and the entry is removed (count decrements).
- With 3 entries buffered and acc=500, assert rst=0 asynchronously mid-cycle → immediately count=0, out_valid=0, acc=0. The first push after release appears at out_data one cycle later.
